// File: rtl/ram_stream_reader_pkg.sv
// Shared constants for the RAM stream reader: data width default and FSM state encodings.
package ram_stream_reader_pkg;

    localparam int unsigned data_len = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/ram_stream_reader_if.sv
// RAM read port plus valid/ready output stream. The reader drives the master side.
interface ram_stream_reader_if
    import ram_stream_reader_pkg::*;
#(
    parameter int unsigned dwidth = data_len,
    parameter int unsigned awidth = 12
);
    logic              ram_load;
    logic [awidth-1:0] ram_addr;
    logic [dwidth-1:0] ram_q;
    logic [dwidth-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output ram_load, ram_addr, m_data, m_valid, m_last,
        input  ram_q, m_ready
    );

    modport slave (
        input  ram_load, ram_addr, m_data, m_valid, m_last,
        output ram_q, m_ready
    );
endinterface

// File: rtl/ram_stream_fifo2.sv
// Two-entry synchronous FIFO with a registered head; a pop frees its slot for a same-cycle push.
module ram_stream_fifo2 #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic [1:0]       count
);
    logic [width-1:0] head_q, head_d;
    logic [width-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = wdata;
                else                 tail_d = wdata;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = wdata;
                end else begin
                    head_d = wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            assert (!(push && !pop && count_q == 2'd2));
        end
    end

    assign rdata = head_q;
    assign count = count_q;
endmodule

// File: rtl/ram_stream_reader.sv
// Reads len consecutive words from a 1-cycle-latency block RAM and streams them out with
// full backpressure, using a 2-entry FIFO to absorb the read pipeline.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int unsigned dwidth = data_len,
    parameter int unsigned awidth = 12,
    parameter int unsigned words  = 12 * 288
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [awidth-1:0]   base_addr,
    input  logic [awidth:0]     len,
    output logic                busy,
    output logic                done,
    ram_stream_reader_if.master bus
);
    localparam logic [awidth:0]   cnt_one  = (awidth + 1)'(1);
    localparam logic [awidth-1:0] addr_one = awidth'(1);
    localparam logic [awidth-1:0] addr_max = awidth'(words - 1);

    logic [1:0]        state_q, state_d;
    logic [awidth:0]   issue_cnt_q, beat_cnt_q, push_cnt_q;
    logic [awidth-1:0] next_addr_q, ram_addr_q;
    logic              inflight_q, qvalid_q, qvalid_d;
    logic [1:0]        fifo_cnt, fifo_cnt_next;
    logic              accept, push, pop, issue;
    logic [dwidth:0]   fifo_head;

    assign accept        = (state_q == IDLE) && start;
    assign pop           = bus.m_valid && bus.m_ready;
    assign push          = qvalid_q && ((fifo_cnt != 2'd2) || pop);
    assign fifo_cnt_next = fifo_cnt + {1'b0, push} - {1'b0, pop};

    // ram_q may wait for FIFO space: with no read in flight ram_addr is unchanged, so the RAM
    // re-reads the same word. Never issue if that waiting word could collide with a new read.
    assign qvalid_d = inflight_q || (qvalid_q && !push);
    assign issue    = (state_q == RUN) && (issue_cnt_q != '0)
                   && !(qvalid_d && (fifo_cnt_next == 2'd2));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
            RUN:     if (pop && (beat_cnt_q == cnt_one)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            push_cnt_q  <= '0;
            next_addr_q <= '0;
            ram_addr_q  <= '0;
            inflight_q  <= 1'b0;
            qvalid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            qvalid_q   <= qvalid_d;
            if (accept) begin
                next_addr_q <= base_addr;
                issue_cnt_q <= len;
                beat_cnt_q  <= len;
                push_cnt_q  <= len;
            end else begin
                if (issue) begin
                    ram_addr_q  <= next_addr_q;
                    next_addr_q <= (next_addr_q == addr_max) ? '0 : next_addr_q + addr_one;
                    issue_cnt_q <= issue_cnt_q - cnt_one;
                end
                if (pop)  beat_cnt_q <= beat_cnt_q - cnt_one;
                if (push) push_cnt_q <= push_cnt_q - cnt_one;
            end
        end
    end

    ram_stream_fifo2 #(
        .width(dwidth + 1)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata({push_cnt_q == cnt_one, bus.ram_q}),
        .rdata(fifo_head),
        .count(fifo_cnt)
    );

    assign bus.m_valid  = (fifo_cnt != 2'd0);
    assign bus.m_last   = fifo_head[dwidth];
    assign bus.m_data   = fifo_head[dwidth-1:0];
    assign bus.ram_load = 1'b0;
    assign bus.ram_addr = ram_addr_q;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
endmodule
